// File: rtl/bios_pkg.sv
// Shared definitions for the BIOS program loader: state encoding, HALT opcode,
// fetch-select encoding and default widths.
package bios_pkg;

  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefMemAddrWidth = 10;
  localparam int unsigned DefSrcAddrWidth = 16;
  localparam int unsigned DefMaxWords     = 1024;

  localparam logic [5:0] HaltOpcode = 6'b011101;

  // Fetch mux select carried on handoff.
  localparam logic SelBios   = 1'b0;
  localparam logic SelMemory = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StWrite,
    StDone,
    StHanded,
    StError
  } loader_state_e;

endpackage

// File: rtl/bios_program_loader.sv
// Copies a program image from storage into instruction memory, then hands fetch over to memory.
// Optional build macro LOADER_HALT_STOP_EN: a word carrying the HALT opcode ends the copy early.
module bios_program_loader
  import bios_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned MEM_ADDR_WIDTH = DefMemAddrWidth,
  parameter int unsigned SRC_ADDR_WIDTH = DefSrcAddrWidth,
  parameter int unsigned MAX_WORDS      = DefMaxWords
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SRC_ADDR_WIDTH-1:0] base_addr,
  input  logic [MEM_ADDR_WIDTH:0]   word_count,
  output logic                      src_rd_en,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     src_data,
  input  logic                      src_valid,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      handoff,
  output logic                      core_rst,
  output logic                      error
);

  localparam int unsigned CntW = MEM_ADDR_WIDTH + 1;

  loader_state_e             state_q, state_d;
  logic [SRC_ADDR_WIDTH-1:0] base_q, base_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [CntW-1:0]           index_q, index_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      count_ok;
  logic                      last_word;
  logic                      halt_word;

  assign count_ok  = (word_count != '0) && (32'(word_count) <= MAX_WORDS);
  assign last_word = (index_q == count_q - CntW'(1));

`ifdef LOADER_HALT_STOP_EN
  assign halt_word = (data_q[DATA_WIDTH-1 -: 6] == HaltOpcode);
`else
  assign halt_word = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    index_d     = index_q;
    data_d      = data_q;
    src_rd_en   = 1'b0;
    src_addr    = base_q + SRC_ADDR_WIDTH'(index_q);
    mem_wr_en   = 1'b0;
    mem_addr    = index_q[MEM_ADDR_WIDTH-1:0];
    mem_wr_data = data_q;
    busy        = 1'b0;
    done        = 1'b0;
    handoff     = SelBios;
    core_rst    = 1'b0;
    error       = 1'b0;

    unique case (state_q)
      StIdle, StError: begin
        error = (state_q == StError);
        if (start) begin
          if (count_ok) begin
            base_d  = base_addr;
            count_d = word_count;
            index_d = '0;
            state_d = StReq;
          end else begin
            state_d = StError;
          end
        end
      end
      StReq: begin
        busy      = 1'b1;
        src_rd_en = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (src_valid) begin
          data_d  = src_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        if (last_word || halt_word) begin
          state_d = StDone;
        end else begin
          index_d = index_q + CntW'(1);
          state_d = StReq;
        end
      end
      StDone: begin
        done     = 1'b1;
        core_rst = 1'b1;
        handoff  = SelMemory;
        state_d  = StHanded;
      end
      StHanded: begin
        handoff = SelMemory;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
